// File: rtl/encoder_pulse_gen_pkg.sv
// Shared definitions for the encoder pulse emulator: pulse bit indices,
// FSM state encodings and a helper that maps a direction to its pulse bit.
package encoder_pulse_gen_pkg;

  // Bit positions on ENC_PULSES_DIR; the downstream counter uses the same indices
  localparam int ENC_INC_BIT = 0;
  localparam int ENC_DEC_BIT = 1;

  // FSM state encodings, kept as plain constants for compatibility with older blocks
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  // Direction of a command, taken straight from the sign bit of the step count
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } enc_dir_e;

  // One-hot pulse pattern for a direction; never both bits at once
  function automatic logic [1:0] dir_to_pulse(input enc_dir_e dir);
    logic [1:0] pulse;
    pulse = 2'b00;
    if (dir == DIR_DEC) begin
      pulse[ENC_DEC_BIT] = 1'b1;
    end else begin
      pulse[ENC_INC_BIT] = 1'b1;
    end
    return pulse;
  endfunction

endpackage

// File: rtl/encoder_pulse_gen_if.sv
// Command/status bundle of the encoder pulse emulator. The master side issues
// step commands and watches the pulse train; the slave side is the emulator.
interface encoder_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
);

  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic signed [CNT_W-1:0] CMD_STEPS;
  logic        [DIV_W-1:0] CMD_PERIOD;
  logic        [DIV_W-1:0] CMD_WIDTH;
  logic                    ABORT;
  logic        [1:0]       ENC_PULSES_DIR;
  logic                    BUSY;
  logic                    DONE;
  logic        [CNT_W-1:0] SENT;

  modport master (
    output CMD_VALID,
    output CMD_STEPS,
    output CMD_PERIOD,
    output CMD_WIDTH,
    output ABORT,
    input  CMD_READY,
    input  ENC_PULSES_DIR,
    input  BUSY,
    input  DONE,
    input  SENT
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_STEPS,
    input  CMD_PERIOD,
    input  CMD_WIDTH,
    input  ABORT,
    output CMD_READY,
    output ENC_PULSES_DIR,
    output BUSY,
    output DONE,
    output SENT
  );

endinterface

// File: rtl/encoder_pulse_gen_pulse_phase_timer.sv
// Loadable down-counter that times one phase (high or low) of a pulse.
// Loading N makes expire rise in the N-th cycle after the load edge,
// i.e. in the last cycle of a phase that lasts N cycles.
module encoder_pulse_gen_pulse_phase_timer #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] remaining;

  // Reload on phase entry, otherwise count down and rest at zero
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= (load_val == '0) ? '0 : load_val - DIV_W'(1);
    end else if (remaining != '0) begin
      remaining <= remaining - DIV_W'(1);
    end
  end

  assign expire = (remaining == '0);

endmodule

// File: rtl/encoder_pulse_gen.sv
// Encoder pulse emulator: converts a signed step command into a train of
// inc/dec pulses with programmable period and high time, so the encoder
// counter can be exercised without a physical encoder.
module encoder_pulse_gen
  import encoder_pulse_gen_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  encoder_pulse_gen_if.slave bus
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;

  enc_dir_e         dir_q;
  enc_dir_e         dir_d;
  logic [DIV_W-1:0] per_q;
  logic [DIV_W-1:0] wid_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] sent_q;
  logic             abort_pend_q;
  logic [1:0]       enc_q;

  logic [CNT_W-1:0] steps_raw;
  logic [CNT_W-1:0] cmd_mag;
  enc_dir_e         cmd_dir;
  logic [DIV_W-1:0] cmd_per;
  logic [DIV_W-1:0] cmd_wid;

  logic             accept;
  logic             enter_high;
  logic             timer_load;
  logic [DIV_W-1:0] timer_val;
  logic             timer_exp;

  // Normalise the incoming command: magnitude, direction, period floor and width clamp.
  // The most negative step count negates to itself, which reads correctly as unsigned.
  always_comb begin
    steps_raw = bus.CMD_STEPS;
    cmd_dir   = enc_dir_e'(steps_raw[CNT_W-1]);
    cmd_mag   = steps_raw[CNT_W-1] ? (~steps_raw + CNT_W'(1)) : steps_raw;
    cmd_per   = (bus.CMD_PERIOD < DIV_W'(2)) ? DIV_W'(2) : bus.CMD_PERIOD;
    if (bus.CMD_WIDTH == '0) begin
      cmd_wid = DIV_W'(1);
    end else if (bus.CMD_WIDTH >= cmd_per) begin
      cmd_wid = cmd_per - DIV_W'(1);
    end else begin
      cmd_wid = bus.CMD_WIDTH;
    end
  end

  assign accept     = bus.CMD_VALID && (state_q == IDLE);
  assign enter_high = (state_d == HIGH) && (state_q != HIGH);
  assign dir_d      = accept ? cmd_dir : dir_q;

  // Next-state logic; also decides when and with what the phase timer is reloaded
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = wid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_mag == '0) begin
            state_d = FIN;
          end else begin
            state_d    = HIGH;
            timer_load = 1'b1;
            timer_val  = cmd_wid;
          end
        end
      end
      HIGH: begin
        if (timer_exp) begin
          if (abort_pend_q || bus.ABORT) begin
            state_d = FIN;
          end else begin
            state_d    = LOW;
            timer_load = 1'b1;
            timer_val  = per_q - wid_q;
          end
        end
      end
      LOW: begin
        if (bus.ABORT) begin
          state_d = FIN;
        end else if (timer_exp) begin
          if (rem_q == '0) begin
            state_d = FIN;
          end else begin
            state_d    = HIGH;
            timer_load = 1'b1;
            timer_val  = wid_q;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  encoder_pulse_gen_pulse_phase_timer #(
    .DIV_W (DIV_W)
  ) u_pulse_phase_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_exp)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the normalised command parameters when a command is taken
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dir_q <= DIR_INC;
      per_q <= DIV_W'(2);
      wid_q <= DIV_W'(1);
    end else if (accept) begin
      dir_q <= cmd_dir;
      per_q <= cmd_per;
      wid_q <= cmd_wid;
    end
  end

  // Remaining-pulse and sent-pulse bookkeeping; the first pulse starts on the accept edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rem_q  <= '0;
      sent_q <= '0;
    end else if (accept) begin
      rem_q  <= (cmd_mag == '0) ? '0 : cmd_mag - CNT_W'(1);
      sent_q <= (cmd_mag == '0) ? '0 : CNT_W'(1);
    end else if (enter_high) begin
      rem_q  <= (rem_q == '0) ? '0 : rem_q - CNT_W'(1);
      sent_q <= sent_q + CNT_W'(1);
    end
  end

  // Remember an abort seen anywhere in a high phase so the pulse is finished, not cut
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      abort_pend_q <= 1'b0;
    end else begin
      abort_pend_q <= (state_q == HIGH) && (state_d == HIGH) && (abort_pend_q || bus.ABORT);
    end
  end

  // Registered pulse outputs, driven from the next state so they align with HIGH
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      enc_q <= 2'b00;
    end else begin
      enc_q <= (state_d == HIGH) ? dir_to_pulse(dir_d) : 2'b00;
    end
  end

  assign bus.CMD_READY      = (state_q == IDLE);
  assign bus.BUSY           = (state_q == HIGH) || (state_q == LOW);
  assign bus.DONE           = (state_q == FIN);
  assign bus.SENT           = sent_q;
  assign bus.ENC_PULSES_DIR = enc_q;

endmodule
